// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter feeding a single sdram_ctrl_wb slave port; port 0 is video, port 1 is CPU.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break (default: fixed priority, port 0 wins).
module sdram_wb_arbiter #(
    parameter int WB_ADDR_WIDTH = 24,
    parameter int WB_DATA_WIDTH = 16,
    parameter int MAX_HOLD      = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       m0_cyc_i,
    input  logic                       m0_stb_i,
    input  logic                       m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [WB_DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                       m0_ack_o,
    output logic [WB_DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                       m1_cyc_i,
    input  logic                       m1_stb_i,
    input  logic                       m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [WB_DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                       m1_ack_o,
    output logic [WB_DATA_WIDTH-1:0]   m1_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_o,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                       s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_i,
    output logic [1:0]                 grant_o
);

    // Handshake: Wishbone classic; a transfer completes on every clock where cyc & stb & ack are
    // high. The arbiter only steers cyc/stb and gates ack, it never creates or stretches a transfer.

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_hold_cnt;
    logic       w_req0;
    logic       w_req1;
    logic       w_tie_pick1;
    logic       w_hold_done;

    assign w_req0      = m0_cyc_i & m0_stb_i;
    assign w_req1      = m1_cyc_i & m1_stb_i;
    assign w_hold_done = s_ack_i & (r_hold_cnt == HOLD_LAST);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic r_last_gnt1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_last_gnt1 <= 1'b1;
        end else if (r_state == IDLE && w_next == GNT0) begin
            r_last_gnt1 <= 1'b0;
        end else if (r_state == IDLE && w_next == GNT1) begin
            r_last_gnt1 <= 1'b1;
        end
    end

    assign w_tie_pick1 = ~r_last_gnt1;
`else
    assign w_tie_pick1 = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter sits at zero throughout IDLE, so every new grant starts from a clean count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state == IDLE) begin
            r_hold_cnt <= 8'd0;
        end else if (s_ack_i) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = w_tie_pick1 ? GNT1 : GNT0;
                end else if (w_req0) begin
                    w_next = GNT0;
                end else if (w_req1) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || w_hold_done) begin
                    w_next = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || w_hold_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        grant_o  = 2'b00;
        if (!wb_rst_i) begin
            case (r_state)
                GNT0: begin
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    s_we_o   = m0_we_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    s_sel_o  = m0_sel_i;
                    m0_ack_o = s_ack_i;
                    grant_o  = 2'b01;
                end
                GNT1: begin
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    s_sel_o  = m1_sel_i;
                    m1_ack_o = s_ack_i;
                    grant_o  = 2'b10;
                end
                default: ;
            endcase
        end
    end

    // Read data is broadcast; only the ack tells a master the data is for it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
